// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_EXEC = 2'd3
  } ifu_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_MISALIGN = 2'd1,
    CAUSE_BUSERR   = 2'd2
  } ifu_cause_e;

  localparam logic [31:0] NOP_INSN  = 32'h0000_0013;
  localparam logic [1:0]  RESP_OKAY = 2'b00;

  function automatic logic pc_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ifu_perf_cnt.sv
// Pair of saturating event counters for fetch performance monitoring.
module ifu_perf_cnt #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_a,
  input  logic         inc_b,
  output logic [W-1:0] cnt_a,
  output logic [W-1:0] cnt_b
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (inc_a && cnt_a != {W{1'b1}}) cnt_a <= cnt_a + W'(1);
      if (inc_b && cnt_b != {W{1'b1}}) cnt_b <= cnt_b + W'(1);
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, one bus read per instruction, hands words to decode.
// Optional perf counters are built when IFU_PERF_CNT_EN is defined.
//
// state  | meaning
// S_REQ  | drive fetch address (or raise misalign fault without a bus request)
// S_WAIT | address accepted, waiting for read data
// S_HOLD | word/pc/fault presented to decode until accepted
// S_EXEC | instruction downstream, waiting for the committed next pc
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          CNT_W    = 64
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_arvalid,
  output logic [31:0] imem_araddr,
  input  logic        imem_arready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic [1:0]  imem_rresp,
  output logic        imem_rready,
  output logic        ifu_valid,
  output logic [31:0] ins,
  output logic [31:0] pc,
  input  logic        idu_ready,
  input  logic        pc_update,
  input  logic [31:0] pc_next,
  output logic        ifu_fault,
  output logic [1:0]  fault_cause
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] perf_fetch_cnt,
  output logic [CNT_W-1:0] perf_stall_cnt
`endif
);

  ifu_state_e  state;
  ifu_cause_e  cause_q;
  logic [31:0] pc_q;
  logic [31:0] ins_q;
  logic        arvalid_q;
  logic        fault_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_REQ;
      pc_q      <= RESET_PC;
      ins_q     <= '0;
      arvalid_q <= 1'b0;
      fault_q   <= 1'b0;
      cause_q   <= CAUSE_NONE;
    end else begin
      case (state)
        S_REQ: begin
          // First cycle in S_REQ decides between a bus request and a misalign fault.
          if (!arvalid_q) begin
            if (pc_misaligned(pc_q)) begin
              ins_q   <= NOP_INSN;
              fault_q <= 1'b1;
              cause_q <= CAUSE_MISALIGN;
              state   <= S_HOLD;
            end else begin
              arvalid_q <= 1'b1;
            end
          end else if (imem_arready) begin
            arvalid_q <= 1'b0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (imem_rresp != RESP_OKAY) begin
              ins_q   <= NOP_INSN;
              fault_q <= 1'b1;
              cause_q <= CAUSE_BUSERR;
            end else begin
              ins_q <= imem_rdata;
            end
            state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (idu_ready) state <= S_EXEC;
        end
        S_EXEC: begin
          if (pc_update) begin
            pc_q    <= pc_next;
            fault_q <= 1'b0;
            cause_q <= CAUSE_NONE;
            state   <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

  assign imem_arvalid = arvalid_q;
  assign imem_araddr  = pc_q;
  assign imem_rready  = (state == S_WAIT);
  assign ifu_valid    = (state == S_HOLD);
  assign ins          = ins_q;
  assign pc           = pc_q;
  assign ifu_fault    = fault_q;
  assign fault_cause  = cause_q;

  // Downstream must only commit a next pc while the instruction is out for execution.
  assert property (@(posedge clk) disable iff (rst) pc_update |-> (state == S_EXEC));

`ifdef IFU_PERF_CNT_EN
  ifu_perf_cnt #(.W(CNT_W)) u_perf_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_a (ifu_valid && idu_ready),
    .inc_b ((state == S_REQ) || (state == S_WAIT)),
    .cnt_a (perf_fetch_cnt),
    .cnt_b (perf_stall_cnt)
  );
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: expected words queued as bus responses are driven.
module tb_ifu_fetch;
  import ifu_pkg::*;

  localparam int CNT_W = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_arvalid;
  logic [31:0] imem_araddr;
  logic        imem_arready = 1'b0;
  logic        imem_rvalid  = 1'b0;
  logic [31:0] imem_rdata   = '0;
  logic [1:0]  imem_rresp   = '0;
  logic        imem_rready;
  logic        ifu_valid;
  logic [31:0] ins;
  logic [31:0] pc;
  logic        idu_ready = 1'b0;
  logic        pc_update = 1'b0;
  logic [31:0] pc_next   = '0;
  logic        ifu_fault;
  logic [1:0]  fault_cause;
`ifdef IFU_PERF_CNT_EN
  logic [CNT_W-1:0] perf_fetch_cnt;
  logic [CNT_W-1:0] perf_stall_cnt;
`endif

  ifu_fetch #(.RESET_PC(32'h8000_0000), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_arvalid (imem_arvalid),
    .imem_araddr  (imem_araddr),
    .imem_arready (imem_arready),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .imem_rresp   (imem_rresp),
    .imem_rready  (imem_rready),
    .ifu_valid    (ifu_valid),
    .ins          (ins),
    .pc           (pc),
    .idu_ready    (idu_ready),
    .pc_update    (pc_update),
    .pc_next      (pc_next),
    .ifu_fault    (ifu_fault),
    .fault_cause  (fault_cause)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
    logic        fault;
    logic [1:0]  cause;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;
  int   handshakes = 0;

  // Bus responder for one fetch; reports what it observed, compares nothing.
  task automatic serve_fetch(input int ar_delay, input logic [31:0] data, input logic [1:0] resp,
                             output logic [31:0] addr, output bit stable, output bit rready_ok,
                             output bit no_extra, output int cycles, output bit ok);
    int n;
    stable = 1; rready_ok = 1; no_extra = 1; ok = 0; addr = 'x;
    n = 0;
    while (imem_arvalid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    cycles = n;
    if (imem_arvalid !== 1'b1) return;
    addr = imem_araddr;
    repeat (ar_delay) begin
      @(negedge clk);
      cycles++;
      if (imem_arvalid !== 1'b1 || imem_araddr !== addr) stable = 0;
    end
    imem_arready = 1'b1;
    @(negedge clk);
    cycles++;
    imem_arready = 1'b0;
    rready_ok = (imem_rready === 1'b1);
    if (imem_arvalid !== 1'b0) no_extra = 0;
    imem_rvalid = 1'b1; imem_rdata = data; imem_rresp = resp;
    @(negedge clk);
    cycles++;
    imem_rvalid = 1'b0; imem_rdata = '0; imem_rresp = '0;
    if (imem_arvalid !== 1'b0) no_extra = 0;
    ok = (ifu_valid === 1'b1);
  endtask

  task automatic retire(input logic [31:0] nxt, output bit dropped);
    idu_ready = 1'b1;
    @(negedge clk);
    idu_ready = 1'b0;
    handshakes++;
    dropped = (ifu_valid === 1'b0);
    pc_update = 1'b1; pc_next = nxt;
    @(negedge clk);
    pc_update = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({imem_arvalid, imem_rready, ifu_valid, ifu_fault, fault_cause} !== 6'b0)
      $display("FAIL reset_ctrl got %b expected 000000",
               {imem_arvalid, imem_rready, ifu_valid, ifu_fault, fault_cause});
    else passed++;
    checks++;
    if ({ins, pc} !== {32'h0, 32'h8000_0000})
      $display("FAIL reset_ins_pc got ins=%h pc=%h expected ins=00000000 pc=80000000", ins, pc);
    else passed++;
  endtask

  task automatic test_first_fetch();
    logic [31:0] addr; bit st, rr, ne, ok; int cyc; exp_t e;
    sb.push_back({32'h0010_0093, 32'h8000_0000, 1'b0, 2'd0});
    rst = 1'b0;
    serve_fetch(0, 32'h0010_0093, 2'b00, addr, st, rr, ne, cyc, ok);
    checks++;
    if (addr !== 32'h8000_0000) $display("FAIL first_addr got %h expected 80000000", addr);
    else passed++;
    checks++;
    if (cyc !== 3 || !ok) $display("FAIL first_latency got %0d valid=%0d expected 3 valid=1", cyc, ok);
    else passed++;
    checks++;
    if (!rr) $display("FAIL first_rready got 0 expected 1");
    else passed++;
    e = sb.pop_front();
    checks++;
    if ({ins, pc, ifu_fault, fault_cause} !== e)
      $display("FAIL first_word got ins=%h pc=%h f=%b c=%0d expected ins=%h pc=%h f=%b c=%0d",
               ins, pc, ifu_fault, fault_cause, e.ins, e.pc, e.fault, e.cause);
    else passed++;
  endtask

  task automatic test_stall();
    bit dropped;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({ifu_valid, ins, pc} !== {1'b1, 32'h0010_0093, 32'h8000_0000})
        $display("FAIL stall_hold cycle %0d got v=%b ins=%h pc=%h expected v=1 ins=00100093 pc=80000000",
                 i, ifu_valid, ins, pc);
      else passed++;
    end
    retire(32'h8000_0100, dropped);
    checks++;
    if (!dropped) $display("FAIL stall_drop got ifu_valid=1 expected 0");
    else passed++;
  endtask

  task automatic test_redirect();
    logic [31:0] addr; bit st, rr, ne, ok, dropped; int cyc; exp_t e;
    sb.push_back({32'h0020_8113, 32'h8000_0100, 1'b0, 2'd0});
    serve_fetch(0, 32'h0020_8113, 2'b00, addr, st, rr, ne, cyc, ok);
    checks++;
    if (addr !== 32'h8000_0100) $display("FAIL redirect_addr got %h expected 80000100", addr);
    else passed++;
    checks++;
    if (!ne || cyc !== 3) $display("FAIL redirect_single_req got extra=%0d cycles=%0d expected 0 and 3", !ne, cyc);
    else passed++;
    e = sb.pop_front();
    checks++;
    if ({ins, pc, ifu_fault, fault_cause} !== e)
      $display("FAIL redirect_word got ins=%h pc=%h f=%b c=%0d expected ins=%h pc=%h",
               ins, pc, ifu_fault, fault_cause, e.ins, e.pc);
    else passed++;
    retire(32'h8000_0102, dropped);
  endtask

  task automatic test_misalign();
    bit req_seen, dropped; int n; exp_t e;
    sb.push_back({NOP_INSN, 32'h8000_0102, 1'b1, 2'd1});
    req_seen = 0; n = 0;
    while (ifu_valid !== 1'b1 && n < 10) begin
      if (imem_arvalid !== 1'b0) req_seen = 1;
      @(negedge clk);
      n++;
    end
    if (imem_arvalid !== 1'b0) req_seen = 1;
    checks++;
    if (req_seen) $display("FAIL misalign_no_req got arvalid=1 expected 0");
    else passed++;
    e = sb.pop_front();
    checks++;
    if ({ins, pc, ifu_fault, fault_cause} !== e || ifu_valid !== 1'b1)
      $display("FAIL misalign_word got v=%b ins=%h pc=%h f=%b c=%0d expected v=1 ins=%h pc=%h f=1 c=1",
               ifu_valid, ins, pc, ifu_fault, fault_cause, e.ins, e.pc);
    else passed++;
    retire(32'h8000_0200, dropped);
    checks++;
    if ({ifu_fault, fault_cause} !== 3'b000)
      $display("FAIL misalign_clear got f=%b c=%0d expected f=0 c=0", ifu_fault, fault_cause);
    else passed++;
  endtask

  task automatic test_bus_error();
    logic [31:0] addr; bit st, rr, ne, ok, dropped; int cyc; exp_t e;
    sb.push_back({NOP_INSN, 32'h8000_0200, 1'b1, 2'd2});
    serve_fetch(4, 32'hdead_beef, 2'b10, addr, st, rr, ne, cyc, ok);
    checks++;
    if (addr !== 32'h8000_0200 || !st)
      $display("FAIL buserr_addr_hold got addr=%h stable=%0d expected 80000200 stable=1", addr, st);
    else passed++;
    e = sb.pop_front();
    checks++;
    if ({ins, pc, ifu_fault, fault_cause} !== e || !ok)
      $display("FAIL buserr_word got v=%0d ins=%h pc=%h f=%b c=%0d expected v=1 ins=%h pc=%h f=1 c=2",
               ok, ins, pc, ifu_fault, fault_cause, e.ins, e.pc);
    else passed++;
    retire(32'h8000_0204, dropped);
  endtask

  task automatic test_back_to_back();
    logic [31:0] addr, exp_pc, d; bit st, rr, ne, ok, dropped; int cyc; exp_t e;
    exp_pc = 32'h8000_0204;
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      sb.push_back({d, exp_pc, 1'b0, 2'd0});
      serve_fetch($urandom_range(0, 2), d, 2'b00, addr, st, rr, ne, cyc, ok);
      e = sb.pop_front();
      checks++;
      if (addr !== exp_pc || {ins, pc, ifu_fault, fault_cause} !== e || !ok)
        $display("FAIL b2b_%0d got addr=%h ins=%h pc=%h f=%b expected addr=%h ins=%h pc=%h f=0",
                 i, addr, ins, pc, ifu_fault, exp_pc, e.ins, e.pc);
      else passed++;
      retire(exp_pc + 32'd4, dropped);
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] addr; bit st, rr, ne, ok, dropped, leak; int n, cyc; exp_t e;
    n = 0;
    while (imem_arvalid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    imem_arready = 1'b1;
    @(negedge clk);
    imem_arready = 1'b0;
    checks++;
    if (imem_rready !== 1'b1) $display("FAIL rstmid_in_wait got rready=%b expected 1", imem_rready);
    else passed++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hbadb_ad00; imem_rresp = 2'b00;
    leak = 0;
    repeat (3) begin
      @(negedge clk);
      if (imem_rready !== 1'b0 || ifu_valid !== 1'b0) leak = 1;
    end
    imem_rvalid = 1'b0; imem_rdata = '0;
    checks++;
    if (leak) $display("FAIL rstmid_stale_drop got rready/valid=1 expected 0");
    else passed++;
    checks++;
    if (imem_araddr !== 32'h8000_0000) $display("FAIL rstmid_restart got %h expected 80000000", imem_araddr);
    else passed++;
    sb.push_back({32'h0050_0293, 32'h8000_0000, 1'b0, 2'd0});
    serve_fetch(0, 32'h0050_0293, 2'b00, addr, st, rr, ne, cyc, ok);
    e = sb.pop_front();
    checks++;
    if ({ins, pc, ifu_fault, fault_cause} !== e || !ok)
      $display("FAIL rstmid_word got v=%0d ins=%h pc=%h expected v=1 ins=%h pc=%h", ok, ins, pc, e.ins, e.pc);
    else passed++;
    retire(32'h8000_0004, dropped);
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_stall();
    test_redirect();
    test_misalign();
    test_bus_error();
    test_back_to_back();
    handshakes = handshakes - 0;
    // Reset in test_reset_mid also clears any perf counters, so sample them first.
`ifdef IFU_PERF_CNT_EN
    checks++;
    if (perf_fetch_cnt !== CNT_W'(handshakes))
      $display("FAIL perf_fetch got %0d expected %0d", perf_fetch_cnt, handshakes);
    else passed++;
`endif
    test_reset_mid();
    checks++;
    if (sb.size() !== 0) $display("FAIL scoreboard_left got %0d expected 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
